fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
Read-side master for the team's synchronous FIFO. Pops words through the FIFO read port (fifo_empty / fifo_rd_en / fifo_dout) into a 2-entry output buffer. Presents them as a valid/ready stream with burst framing (m_last) and a transferred-word counter. Sits between a FIFO instance and any downstream stream consumer.

Parameters:
WIDTH, 8, data width; must match the FIFO WIDTH.
BURST_LEN, 4, words per burst; m_last is asserted on every BURST_LEN-th transferred word; legal range 1..256.
CNT_WIDTH, 16, width of word_cnt.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  pop enable; when low, no new FIFO reads are issued, but buffered words still drain
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read strobe
fifo_dout  input  WIDTH  FIFO read data
m_valid  output  1  output word valid
m_ready  input  1  downstream accept
m_data  output  WIDTH  output word (head of buffer)
m_last  output  1  word is the last of its burst; qualified by m_valid
word_cnt  output  CNT_WIDTH  count of completed output handshakes; wraps modulo 2^CNT_WIDTH
busy  output  1  high while occ != 0 or a read is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, word_cnt=0, busy=0. Buffer occupancy, in-flight flag, burst counter and pointers are all cleared.
- Reset mid-operation: buffered and in-flight words are discarded. No handshake completes in the reset cycle.
- Buffer: 2-entry circular, FIFO order. occ (0..2) is held in a 2-bit counter. inflight is 0 or 1 and is used in registered mode only.
- Issue rule (combinational): fifo_rd_en = en && !fifo_empty && (occ + inflight - (m_valid && m_ready) < 2).
  - The m_ready-to-fifo_rd_en combinational path is intentional; it gives 1 word/cycle sustained throughput.
  - A read is never issued while fifo_empty=1, so the FIFO's underflow guard is never relied on.
- Capture: a read is issued in cycle N, and fifo_dout is written to the buffer tail at the end of the capture cycle (see Optional Feature).
- Output:
  - m_valid = (occ != 0).
  - m_data is the head entry.
  - An output handshake is m_valid && m_ready. It advances the head, increments word_cnt, and advances the burst counter.
- Simultaneous capture and handshake in the same cycle: occ is unchanged, and both pointers advance.
- m_valid stability: once asserted, m_valid and m_data hold until the handshake completes. Deasserting en never drops m_valid.
- Burst counter beat:
  - Range 0..BURST_LEN-1, width $clog2(BURST_LEN) (minimum 1 bit).
  - m_last = m_valid && (beat == BURST_LEN-1).
  - On a handshake, beat wraps to 0 when m_last is set, otherwise increments.
  - With BURST_LEN=1, m_last = m_valid.
- word_cnt: rolls from 2^CNT_WIDTH-1 to 0 with no flag.
- en falling while a read is in flight: the in-flight word is still captured.

Optional Feature:
Macro FIFO_RD_REG_EN.
- Defined (registered FIFO output):
  - fifo_dout is valid one cycle after fifo_rd_en. A read issued in cycle N sets inflight=1, and data is captured at the end of cycle N+1.
  - First-word latency: fifo_rd_en in cycle N, m_valid in cycle N+2.
- Undefined (show-ahead FIFO output):
  - fifo_dout is valid in the same cycle as !fifo_empty. Data is captured at the end of the issue cycle, and inflight is tied to 0.
  - First-word latency: fifo_rd_en in cycle N, m_valid in cycle N+1.
- Both modes sustain 1 word/cycle while m_ready=1 and the FIFO is non-empty.

Test Plan:
1. Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44; en=1, m_ready=1 -> m_data 0x11..0x44 on consecutive cycles; m_last only with 0x44; word_cnt=4; busy=0 afterwards.
2. FIFO holds 6 words; m_ready=0 -> exactly 2 reads issued, fifo_rd_en then stays 0, and m_data=first word holds; raise m_ready -> remaining 4 words delivered in order with no gaps.
3. en=0 with 2 buffered words and FIFO non-empty -> both words drain, fifo_rd_en stays 0 and m_valid falls; en=1 -> popping resumes.
4. rst pulsed asynchronously mid-burst (occ=2, beat=2) -> all outputs are 0 immediately; after release, the next word carries beat 0 (m_last only on the 4th word).
5. CNT_WIDTH=4: 17 handshakes -> word_cnt reads 15 and then 0 after the 16th, and 1 after the 17th.
6. Run scenarios 1 and 2 with FIFO_RD_REG_EN defined against a registered-output FIFO model -> identical output sequences; first m_valid 2 cycles after the first fifo_rd_en (1 cycle when undefined).

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side master into a 2-entry buffer, valid/ready burst stream out (FIFO_RD_REG_EN: registered FIFO output)
module fifo_rd_stream #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);

  localparam int              BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic [WIDTH-1:0]  buf_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic [BEAT_W-1:0] beat;
  logic              hs;
  logic              cap;
  logic [2:0]        pending;
  logic              room;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_mem[rd_ptr];
  assign m_last  = m_valid && (beat == BEAT_MAX);
  assign hs      = m_valid && m_ready;
  assign busy    = (occ != 2'd0) || inflight;

  // Words already owned by this block (buffered plus in flight); a handshake
  // this cycle frees a slot, which is what keeps throughput at 1 word/cycle.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign room       = hs ? (pending < 3'd3) : (pending < 3'd2);
  assign fifo_rd_en = !rst && en && !fifo_empty && room;

`ifdef FIFO_RD_REG_EN
  // Registered FIFO: data for a read shows up one cycle later, so track it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end
  assign cap = inflight;
`else
  // Show-ahead FIFO: data is on fifo_dout in the issue cycle itself
  assign inflight = 1'b0;
  assign cap      = fifo_rd_en;
`endif

  // Capture incoming FIFO data at the buffer tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
    end else if (cap) begin
      buf_mem[wr_ptr] <= fifo_dout;
      wr_ptr          <= ~wr_ptr;
    end
  end

  // Occupancy and head pointer; capture and handshake together leave occ as is
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      occ <= occ + {1'b0, cap} - {1'b0, hs};
      if (hs) rd_ptr <= ~rd_ptr;
    end
  end

  // Burst beat position and completed-handshake counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat     <= '0;
      word_cnt <= '0;
    end else if (hs) begin
      beat     <= m_last ? '0 : beat + 1'b1;
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule
